// File: rtl/serial_acc_ctrl.sv
// serial_acc_ctrl
//   Accumulates a stream of unsigned operands into a WIDTH-bit running total
//   using a single shared 1-bit full-adder cell (two half adders plus a carry
//   flop). Each accepted operand is added LSB-first over WIDTH cycles. The
//   result and the sticky overflow flag are published together with a
//   one-cycle done pulse. Intermediate sums are never visible on acc.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   clr       in   1      clear acc and ovf (honoured only while idle)
//   in_valid  in   1      in_data is valid
//   in_ready  out  1      operand can be accepted this cycle
//   in_data   in   WIDTH  unsigned operand
//   acc       out  WIDTH  accumulator, modulo 2^WIDTH
//   ovf       out  1      sticky carry-out-of-MSB flag
//   busy      out  1      serial add in progress
//   done      out  1      one-cycle pulse, acc/ovf just updated
module serial_acc_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ADD  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Shared adder cell: first half adder combines the operand bits, the
  // second folds in the stored carry.
  logic ha0_s, ha0_c, ha1_c, sum_bit, carry_out;

  assign ha0_s     = a_q[0] ^ b_q[0];
  assign ha0_c     = a_q[0] & b_q[0];
  assign sum_bit   = ha0_s ^ carry_q;
  assign ha1_c     = ha0_s & carry_q;
  assign carry_out = ha0_c | ha1_c;

  assign in_ready = (state_q == S_IDLE) & ~clr;
  assign busy     = (state_q == S_ADD);
  assign acc      = acc_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          // A holds a snapshot of acc so acc itself stays stable until the
          // final bit is known.
          a_d     = acc_q;
          b_d     = in_data;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        // Sum bits enter A from the top; after WIDTH shifts A holds the sum.
        a_d     = {sum_bit, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          acc_d   = {sum_bit, a_q[WIDTH-1:1]};
          ovf_d   = ovf_q | carry_out;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand shift registers are always reloaded before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

endmodule

// File: tb/tb_serial_acc_ctrl.sv
module tb_serial_acc_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] acc;
  logic         ovf;
  logic         busy;
  logic         done;

  serial_acc_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .acc      (acc),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] acc;
    logic         ovf;
    int           t_acc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain integer arithmetic on the running total.
  int acc_m = 0;
  bit ovf_m = 0;
  int last_accept = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: scoreboard on done, plus busy-window invariants.
  int  run = 0;
  bit  abort = 0;
  logic [W-1:0] acc_hold;
  always @(negedge clk) begin
    if (rst) begin
      if (run > 0) abort = 1;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("acc", acc, e.acc);
          chk("ovf", ovf, e.ovf);
          chk("done_latency", cyc, e.t_acc + W + 1);
          chk("ready_in_done", in_ready, !clr);
        end
      end
      if (busy) begin
        if (run == 0) acc_hold = acc;
        else chk("acc_stable", acc, acc_hold);
        chk("ready_busy", in_ready, 0);
        run++;
      end else begin
        if (run > 0 && !abort) chk("busy_len", run, W);
        run = 0;
        abort = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit hold);
    bit ok = 0;
    int sum;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      sum = acc_m + int'(d);
      if (sum >= (1 << W)) ovf_m = 1;
      acc_m = sum % (1 << W);
      exp_q.push_back('{acc: W'(acc_m), ovf: ovf_m, t_acc: cyc});
      last_accept = cyc;
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    acc_m = 0;
    ovf_m = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1;

    // Simple adds: 3 then 5
    send(8'd3, 0); wait_idle();
    send(8'd5, 0); wait_idle();
    chk("sum_3_5", acc, 8);
    chk("ovf_3_5", ovf, 0);

    // Overflow
    clear();
    send(8'd200, 0); send(8'd100, 0); wait_idle();
    chk("ovf_acc", acc, 44);
    chk("ovf_set", ovf, 1);
    send(8'd1, 0); wait_idle();
    chk("ovf_sticky_acc", acc, 45);
    chk("ovf_sticky", ovf, 1);

    // in_valid held high, back-to-back
    clear();
    send(8'd1, 1); t1 = last_accept;
    send(8'd2, 1); t2 = last_accept;
    send(8'd3, 0); t3 = last_accept;
    wait_idle();
    chk("b2b_acc", acc, 6);
    chk("b2b_gap1", t2 - t1, W + 1);
    chk("b2b_gap2", t3 - t2, W + 1);

    // clr with in_valid in idle: operand dropped
    send(8'd39, 0); wait_idle();
    chk("pre_clr_acc", acc, 45);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd77;
    @(negedge clk);
    chk("clr_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    acc_m = 0; ovf_m = 0;
    @(negedge clk);
    chk("clr_acc", acc, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_busy", busy, 0);
    @(posedge clk); #1;
    // clr while busy ignored
    send(8'd5, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    wait_idle();
    chk("clr_busy_ignored", acc, 5);

    // Reset on the 4th ADD cycle
    clear();
    send(8'd10, 0); wait_idle();
    send(8'd7, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_m = 0; ovf_m = 0;
    @(negedge clk);
    chk("abort_acc", acc, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    send(8'd7, 0); wait_idle();
    chk("after_abort", acc, 7);

    // Randomized stream
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] d;
      int gap;
      d = W'($urandom_range(0, (1 << W) - 1));
      gap = $urandom_range(0, 3);
      send(d, 0);
      if ($urandom_range(0, 3) == 0) begin
        clr = 1'b1;
        in_valid = 1'b1; in_data = W'($urandom);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
      end
      repeat (gap) @(posedge clk);
      #1;
      if ($urandom_range(0, 5) == 0) begin
        wait_idle();
        clear();
      end
    end
    wait_idle();
    chk("final_acc", acc, W'(acc_m));
    chk("final_ovf", ovf, ovf_m);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
